// File: rtl/hs32_div_pkg.sv
// Shared types and constants for the HS32 divider issue/response front end.
package hs32_div_pkg;

  // Sequencing of one divide: accept, pulse issue, let the divider sample
  // operands, wait for both steals, then hand the result back.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT,
    RESP
  } div_state_e;

  // Number of cycles the operands must sit still after the issue pulse
  // while the divider performs its d1/d2 operand sampling.
  localparam int HOLD_CYCLES = 2;

  // Steal-to-result-bus distance of the divider (_6 -> _8).
  localparam int STEAL_LAT_DEFAULT = 2;

  // Everything captured from a request and presented to the divider.
  typedef struct packed {
    logic        div8divh;
    logic        signedOp;
    logic        dualRes;
    logic [3:0]  resEnable;
    logic [63:0] dividendHi;
    logic [63:0] dividendLo;
    logic [63:0] divisor;
  } div_req_t;

endpackage

// File: rtl/hs32_steal_pipe.sv
// Delays a divider steal strobe so that it lines up with its data on the
// result bus.
module hs32_steal_pipe #(
  parameter int STEAL_LAT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic steal_i,
  output logic cap_o
);

  logic [STEAL_LAT-1:0] pipe_q;

  // Shift every cycle regardless of controller state; the consumer decides
  // whether a capture strobe is meaningful.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | STEAL_LAT'(steal_i);
    end
  end

  assign cap_o = pipe_q[STEAL_LAT-1];

endmodule

// File: rtl/hs32_div_issue_ctl.sv
// Request/response front end wrapped around hs32_div_top: issues one divide,
// follows the steal strobes to pick quotient/remainder off the result bus and
// returns them over a valid/ready response channel.
module hs32_div_issue_ctl
  import hs32_div_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STEAL_LAT      = STEAL_LAT_DEFAULT
) (
  input  logic        CCLK,
  input  logic        SSE,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_div8divh,
  input  logic        req_signed,
  input  logic        req_dualres,
  input  logic [3:0]  req_resen,
  input  logic [63:0] req_dividend_hi,
  input  logic [63:0] req_dividend_lo,
  input  logic [63:0] req_divisor,
  output logic        al_is_DivIssue1_8,
  output logic        al_is_Div8Divh1_8,
  output logic        al_is_SignedMulDiv1_8,
  output logic        al_is_DualResMulDiv1_8,
  output logic [3:0]  al_is_ResEnable1_8,
  output logic [63:0] Dividend_hi,
  output logic [63:0] Dividend_lo,
  output logic [63:0] Divisor,
  input  logic        AttemptDivSteal2_6,
  input  logic        AttemptDivSteal1_6,
  input  logic        DivError_8,
  input  logic [63:0] DivResBus_8,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_quotient,
  output logic [63:0] rsp_remainder,
  output logic        rsp_error,
  output logic        rsp_timeout
);

  localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] HOLD_LAST   = 2'(HOLD_CYCLES - 1);

  div_state_e  state_q;
  div_req_t    op_q;
  logic        reqReady_q;
  logic        issue_q;
  logic [1:0]  holdCnt_q;
  logic [7:0]  waitCnt_q;
  logic [7:0]  waitCnt_d;
  logic        gotQuot_q;
  logic        gotRem_q;
  logic        rspValid_q;
  logic [63:0] rspQuot_q;
  logic [63:0] rspRem_q;
  logic        rspError_q;
  logic        rspTimeout_q;

  logic cap2;
  logic cap1;
  logic gotQuotNow;
  logic gotRemNow;
  logic opDone;

  hs32_steal_pipe #(.STEAL_LAT(STEAL_LAT)) u_pipe_quot (
    .clk_i   (CCLK),
    .rst_i   (SSE),
    .steal_i (AttemptDivSteal2_6),
    .cap_o   (cap2)
  );

  hs32_steal_pipe #(.STEAL_LAT(STEAL_LAT)) u_pipe_rem (
    .clk_i   (CCLK),
    .rst_i   (SSE),
    .steal_i (AttemptDivSteal1_6),
    .cap_o   (cap1)
  );

  // A capture arriving this cycle counts toward completion immediately, so a
  // single-result op or a same-cycle quotient/remainder pair leaves WAIT now.
  assign gotQuotNow = gotQuot_q | cap2;
  assign gotRemNow  = gotRem_q | cap1;
  assign opDone     = op_q.dualRes ? (gotQuotNow & gotRemNow) : gotQuotNow;
  assign waitCnt_d  = (waitCnt_q == TIMEOUT_MAX) ? waitCnt_q : waitCnt_q + 8'd1;

  // Whole controller: state sequencing plus every registered output.
  always_ff @(posedge CCLK) begin
    if (SSE) begin
      state_q      <= IDLE;
      op_q         <= '0;
      reqReady_q   <= 1'b0;
      issue_q      <= 1'b0;
      holdCnt_q    <= '0;
      waitCnt_q    <= '0;
      gotQuot_q    <= 1'b0;
      gotRem_q     <= 1'b0;
      rspValid_q   <= 1'b0;
      rspQuot_q    <= '0;
      rspRem_q     <= '0;
      rspError_q   <= 1'b0;
      rspTimeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          reqReady_q <= 1'b1;
          if (req_valid && reqReady_q) begin
            op_q.div8divh   <= req_div8divh;
            op_q.signedOp   <= req_signed;
            op_q.dualRes    <= req_dualres;
            op_q.resEnable  <= req_resen;
            op_q.dividendHi <= req_dividend_hi;
            op_q.dividendLo <= req_dividend_lo;
            op_q.divisor    <= req_divisor;
            reqReady_q      <= 1'b0;
            issue_q         <= 1'b1;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          issue_q   <= 1'b0;
          holdCnt_q <= '0;
          state_q   <= HOLD;
        end
        HOLD: begin
          if (holdCnt_q == HOLD_LAST) begin
            waitCnt_q <= '0;
            state_q   <= WAIT;
          end else begin
            holdCnt_q <= holdCnt_q + 2'd1;
          end
        end
        WAIT: begin
          if (DivError_8) begin
            rspQuot_q  <= '0;
            rspRem_q   <= '0;
            rspError_q <= 1'b1;
            rspValid_q <= 1'b1;
            op_q       <= '0;
            state_q    <= RESP;
          end else begin
            if (cap2) begin
              rspQuot_q <= DivResBus_8;
              gotQuot_q <= 1'b1;
            end
            if (cap1) begin
              rspRem_q <= DivResBus_8;
              gotRem_q <= 1'b1;
            end
            waitCnt_q <= waitCnt_d;
            if (opDone) begin
              rspValid_q <= 1'b1;
              op_q       <= '0;
              state_q    <= RESP;
            end else if (waitCnt_d == TIMEOUT_MAX) begin
              rspValid_q   <= 1'b1;
              rspError_q   <= 1'b1;
              rspTimeout_q <= 1'b1;
              op_q         <= '0;
              state_q      <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q   <= 1'b0;
            rspQuot_q    <= '0;
            rspRem_q     <= '0;
            rspError_q   <= 1'b0;
            rspTimeout_q <= 1'b0;
            gotQuot_q    <= 1'b0;
            gotRem_q     <= 1'b0;
            reqReady_q   <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready              = reqReady_q;
  assign al_is_DivIssue1_8      = issue_q;
  assign al_is_Div8Divh1_8      = op_q.div8divh;
  assign al_is_SignedMulDiv1_8  = op_q.signedOp;
  assign al_is_DualResMulDiv1_8 = op_q.dualRes;
  assign al_is_ResEnable1_8     = op_q.resEnable;
  assign Dividend_hi            = op_q.dividendHi;
  assign Dividend_lo            = op_q.dividendLo;
  assign Divisor                = op_q.divisor;
  assign rsp_valid              = rspValid_q;
  assign rsp_quotient           = rspQuot_q;
  assign rsp_remainder          = rspRem_q;
  assign rsp_error              = rspError_q;
  assign rsp_timeout            = rspTimeout_q;

endmodule
